// File: rtl/nice_cmd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nice_cmd_pkg                                                 |
// | Description : Shared sizing helpers and beat type for the custom0 DWCs.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package nice_cmd_pkg;

    localparam int c_DEF_IN_DATA_WIDTH  = 32;
    localparam int c_DEF_OUT_DATA_WIDTH = 128;

    function automatic int f_ratio(input int in_w, input int out_w);
        return out_w / in_w;
    endfunction

    function automatic int f_cntw(input int ratio);
        return $clog2(ratio) + 1;
    endfunction

    function automatic int f_lvlw(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int c_DEF_CNTW = f_cntw(f_ratio(c_DEF_IN_DATA_WIDTH, c_DEF_OUT_DATA_WIDTH));

    typedef struct packed {
        logic [c_DEF_OUT_DATA_WIDTH-1:0] wdata;
        logic [c_DEF_CNTW-1:0]           wcnt;
    } dwc_beat_t;

endpackage
`default_nettype wire

// File: rtl/nice_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nice_sync_fifo                                               |
// | Description : Single-clock FIFO with registered storage and level output.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module nice_sync_fifo
    import nice_cmd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_push,
    input  logic [WIDTH-1:0]          i_wdata,
    input  logic                      i_pop,
    output logic [WIDTH-1:0]          o_rdata,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [f_lvlw(DEPTH)-1:0]  o_level
);

    localparam int             c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_PTR_ONE = (c_AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
                r_wr_ptr                  <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/nice_cmd_dwc0.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nice_cmd_dwc0                                                |
// | Description : Packs 32-bit custom0 command words into wide beats, buffered |
// |               in a FIFO, with zero-padded flush of partial beats.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module nice_cmd_dwc0
    import nice_cmd_pkg::*;
#(
    parameter int IN_DATA_WIDTH  = 32,
    parameter int OUT_DATA_WIDTH = 128,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        id_cmd_valid0,
    output logic                        id_cmd_ready0,
    input  logic [IN_DATA_WIDTH-1:0]    id_cmd_wdata0,
    input  logic                        id_cmd_flush0,
    output logic                        acc_cmd_valid0,
    input  logic                        acc_cmd_ready0,
    output logic [OUT_DATA_WIDTH-1:0]   acc_cmd_wdata0,
    output logic [f_cntw(f_ratio(IN_DATA_WIDTH, OUT_DATA_WIDTH))-1:0] acc_cmd_wcnt0,
    output logic [f_lvlw(FIFO_DEPTH)-1:0] dwc_level0,
    output logic                        dwc_busy0
);

    localparam int c_RATIO  = f_ratio(IN_DATA_WIDTH, OUT_DATA_WIDTH);
    localparam int c_CNTW   = f_cntw(c_RATIO);
    localparam int c_IDXW   = c_CNTW - 1;
    localparam int c_BEAT_W = OUT_DATA_WIDTH + c_CNTW;
    localparam logic [c_IDXW-1:0] c_IDX_LAST = c_IDXW'(c_RATIO - 1);
    localparam logic [c_IDXW-1:0] c_IDX_ONE  = c_IDXW'(1);

    logic [c_IDXW-1:0]         r_idx;
    logic [OUT_DATA_WIDTH-1:0] r_pack;
    logic                      r_flush_pend;

    logic                      w_valid;
    logic                      w_flush;
    logic                      w_idx_last;
    logic                      w_accept;
    logic                      w_complete;
    logic [c_CNTW-1:0]         w_cnt_after;
    logic                      w_flush_new;
    logic                      w_flush_now;
    logic                      w_flush_defer;
    logic                      w_pend_drain;
    logic                      w_push;
    logic                      w_pop;
    logic [OUT_DATA_WIDTH-1:0] w_pack_word;
    logic [c_BEAT_W-1:0]       w_fifo_wdata;
    logic [c_BEAT_W-1:0]       w_fifo_rdata;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;

    // Inputs are masked during reset so an X from upstream cannot leak in.
    assign w_valid       = id_cmd_valid0 & rst_n;
    assign w_flush       = id_cmd_flush0 & rst_n;
    assign w_idx_last    = (r_idx == c_IDX_LAST);

    // Only a beat-completing word needs a free FIFO slot; pops do not count this cycle.
    assign id_cmd_ready0 = rst_n & ~r_flush_pend & ~(w_fifo_full & w_idx_last);
    assign w_accept      = w_valid & id_cmd_ready0;
    assign w_complete    = w_accept & w_idx_last;
    assign w_cnt_after   = {1'b0, r_idx} + {{(c_CNTW-1){1'b0}}, w_accept};

    assign w_flush_new   = w_flush & ~r_flush_pend & (w_cnt_after != '0) & ~w_complete;
    assign w_flush_now   = w_flush_new & ~w_fifo_full;
    assign w_flush_defer = w_flush_new & w_fifo_full;
    assign w_pend_drain  = r_flush_pend & ~w_fifo_full;
    assign w_push        = w_complete | w_flush_now | w_pend_drain;

    always_comb begin
        w_pack_word = r_pack;
        for (int k = 0; k < c_RATIO; k++) begin
            if (w_accept && (r_idx == c_IDXW'(k))) begin
                w_pack_word[k*IN_DATA_WIDTH +: IN_DATA_WIDTH] = id_cmd_wdata0;
            end
        end
    end

    // During a pending drain no word is accepted, so w_cnt_after equals r_idx.
    assign w_fifo_wdata = {w_cnt_after, w_pack_word};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_pack       <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            if (w_push) begin
                r_idx  <= '0;
                r_pack <= '0;
            end else if (w_accept) begin
                r_idx  <= r_idx + c_IDX_ONE;
                r_pack <= w_pack_word;
            end
            if (w_pend_drain) begin
                r_flush_pend <= 1'b0;
            end else if (w_flush_defer) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    nice_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_BEAT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_fifo_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (dwc_level0)
    );

    assign acc_cmd_valid0 = ~w_fifo_empty;
    assign w_pop          = acc_cmd_valid0 & acc_cmd_ready0;
    assign acc_cmd_wdata0 = w_fifo_rdata[OUT_DATA_WIDTH-1:0];
    assign acc_cmd_wcnt0  = w_fifo_rdata[c_BEAT_W-1 -: c_CNTW];
    assign dwc_busy0      = (r_idx != '0) | r_flush_pend | ~w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_nice_cmd_dwc0.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_nice_cmd_dwc0                                             |
// | Description : Scoreboard bench for the custom0 command width converter.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_nice_cmd_dwc0;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         id_cmd_valid0;
    logic         id_cmd_ready0;
    logic [31:0]  id_cmd_wdata0;
    logic         id_cmd_flush0;
    logic         acc_cmd_valid0;
    logic         acc_cmd_ready0;
    logic [127:0] acc_cmd_wdata0;
    logic [2:0]   acc_cmd_wcnt0;
    logic [2:0]   dwc_level0;
    logic         dwc_busy0;

    typedef struct {
        logic [127:0] d;
        logic [2:0]   c;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           n_checks = 0;
    int           n_fail   = 0;
    logic         stall_prev = 1'b0;
    logic [127:0] stall_d;
    logic [2:0]   stall_c;

    always #5 clk = ~clk;

    nice_cmd_dwc0 dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_cmd_valid0  (id_cmd_valid0),
        .id_cmd_ready0  (id_cmd_ready0),
        .id_cmd_wdata0  (id_cmd_wdata0),
        .id_cmd_flush0  (id_cmd_flush0),
        .acc_cmd_valid0 (acc_cmd_valid0),
        .acc_cmd_ready0 (acc_cmd_ready0),
        .acc_cmd_wdata0 (acc_cmd_wdata0),
        .acc_cmd_wcnt0  (acc_cmd_wcnt0),
        .dwc_level0     (dwc_level0),
        .dwc_busy0      (dwc_busy0)
    );

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_beat(input logic [127:0] d, input logic [2:0] c);
        exp_t e;
        e.d = d;
        e.c = c;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] bpw(input int b, input int w);
        return 32'hC0DE_0000 + 32'(b * 16 + w);
    endfunction

    function automatic logic [127:0] bp_beat(input int b);
        return {bpw(b, 3), bpw(b, 2), bpw(b, 1), bpw(b, 0)};
    endfunction

    // Entry and exit are #1 after a rising edge; holds valid until accepted.
    task automatic send(input logic [31:0] w, input logic fl);
        logic got;
        got           = 1'b0;
        id_cmd_valid0 = 1'b1;
        id_cmd_wdata0 = w;
        id_cmd_flush0 = fl;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = id_cmd_ready0;
            @(posedge clk);
            #1;
        end
        id_cmd_valid0 = 1'b0;
        id_cmd_flush0 = 1'b0;
        chk("send_accept_timeout", got, 1'b1);
    endtask

    task automatic pulse_flush();
        id_cmd_flush0 = 1'b1;
        @(posedge clk);
        #1;
        id_cmd_flush0 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every beat taken by the accelerator is compared in order.
    always @(negedge clk) begin
        if (rst_n && acc_cmd_valid0 && acc_cmd_ready0) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got 0x%0h wcnt %0d, expected no beat",
                         acc_cmd_wdata0, acc_cmd_wcnt0);
            end else begin
                mon_e = sb.pop_front();
                chk("beat_wdata", acc_cmd_wdata0, mon_e.d);
                chk("beat_wcnt", acc_cmd_wcnt0, mon_e.c);
            end
        end
    end

    // Head must not change while the accelerator stalls it.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && acc_cmd_valid0) begin
                chk("stall_hold_wdata", acc_cmd_wdata0, stall_d);
                chk("stall_hold_wcnt", acc_cmd_wcnt0, stall_c);
            end
            stall_prev = acc_cmd_valid0 & ~acc_cmd_ready0;
            stall_d    = acc_cmd_wdata0;
            stall_c    = acc_cmd_wcnt0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        id_cmd_valid0  = 1'b1;
        id_cmd_flush0  = 1'b1;
        id_cmd_wdata0  = 32'hFFFF_FFFF;
        acc_cmd_ready0 = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", id_cmd_ready0, 1'b0);
        chk("rst_acc_valid", acc_cmd_valid0, 1'b0);
        chk("rst_wdata", acc_cmd_wdata0, 128'h0);
        chk("rst_wcnt", acc_cmd_wcnt0, 3'd0);
        chk("rst_level", dwc_level0, 3'd0);
        chk("rst_busy", dwc_busy0, 1'b0);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        id_cmd_valid0 = 1'b0;
        id_cmd_flush0 = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", id_cmd_ready0, 1'b1);
        chk("post_rst_level", dwc_level0, 3'd0);
        @(posedge clk);
        #1;

        // Full pack, one-cycle latency
        send(32'hAAAA_AAAA, 1'b0);
        send(32'hBBBB_BBBB, 1'b0);
        send(32'hCCCC_CCCC, 1'b0);
        chk("pack_no_early_valid", acc_cmd_valid0, 1'b0);
        chk("pack_busy_partial", dwc_busy0, 1'b1);
        expect_beat(128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA, 3'd4);
        send(32'hDDDD_DDDD, 1'b0);
        chk("pack_latency_valid", acc_cmd_valid0, 1'b1);
        idle(2);

        // Flush of a 2-word partial, then flush with nothing held
        send(32'h1111_1111, 1'b0);
        send(32'h2222_2222, 1'b0);
        expect_beat(128'h0000_0000_0000_0000_2222_2222_1111_1111, 3'd2);
        pulse_flush();
        idle(2);
        chk("flush_drained_level", dwc_level0, 3'd0);
        chk("flush_idle_busy", dwc_busy0, 1'b0);
        pulse_flush();
        @(negedge clk);
        chk("flush_idx0_noop", acc_cmd_valid0, 1'b0);
        @(posedge clk);
        #1;

        // Flush in the same cycle as a word
        send(32'h0101_0101, 1'b0);
        send(32'h0202_0202, 1'b0);
        expect_beat(128'h0000_0000_3333_3333_0202_0202_0101_0101, 3'd3);
        send(32'h3333_3333, 1'b1);
        send(32'h4444_4444, 1'b0);
        send(32'h5555_5555, 1'b0);
        send(32'h6666_6666, 1'b0);
        expect_beat(128'h7777_7777_6666_6666_5555_5555_4444_4444, 3'd4);
        send(32'h7777_7777, 1'b1);
        idle(2);
        chk("flush4_single_beat", dwc_level0, 3'd0);
        chk("flush4_no_extra", acc_cmd_valid0, 1'b0);

        // Backpressure: fill the FIFO, last word of beat 5 stalls until a pop
        acc_cmd_ready0 = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < 4; w++) begin
                if (w == 3) expect_beat(bp_beat(b), 3'd4);
                send(bpw(b, w), 1'b0);
            end
        end
        chk("bp_level_full", dwc_level0, 3'd4);
        for (int w = 0; w < 3; w++) send(bpw(4, w), 1'b0);
        id_cmd_valid0 = 1'b1;
        id_cmd_wdata0 = bpw(4, 3);
        expect_beat(bp_beat(4), 3'd4);
        @(negedge clk);
        chk("bp_word4_stalled", id_cmd_ready0, 1'b0);
        @(posedge clk);
        #1;
        acc_cmd_ready0 = 1'b1;
        @(negedge clk);
        chk("bp_pop_no_free", id_cmd_ready0, 1'b0);
        @(posedge clk);
        #1;
        acc_cmd_ready0 = 1'b0;
        @(negedge clk);
        chk("bp_ready_back", id_cmd_ready0, 1'b1);
        @(posedge clk);
        #1;
        id_cmd_valid0 = 1'b0;
        chk("bp_level_refill", dwc_level0, 3'd4);

        // Pending flush while full
        send(32'hE1E1_E1E1, 1'b0);
        send(32'hE2E2_E2E2, 1'b0);
        expect_beat(128'h0000_0000_0000_0000_E2E2_E2E2_E1E1_E1E1, 3'd2);
        pulse_flush();
        @(negedge clk);
        chk("pend_ready_low", id_cmd_ready0, 1'b0);
        chk("pend_busy", dwc_busy0, 1'b1);
        @(posedge clk);
        #1;
        pulse_flush();
        acc_cmd_ready0 = 1'b1;
        @(posedge clk);
        #1;
        acc_cmd_ready0 = 1'b0;
        chk("pend_level_after_pop", dwc_level0, 3'd3);
        chk("pend_still_stalled", id_cmd_ready0, 1'b0);
        @(posedge clk);
        #1;
        chk("pend_ready_return", id_cmd_ready0, 1'b1);
        chk("pend_level_refill", dwc_level0, 3'd4);

        acc_cmd_ready0 = 1'b1;
        for (int n = 0; n < 40 && (dwc_level0 != 3'd0); n++) idle(1);
        idle(1);
        chk("drain_level", dwc_level0, 3'd0);
        chk("drain_scoreboard_empty", 32'(sb.size()), 32'd0);

        // Reset mid-operation discards beats and the partial word
        acc_cmd_ready0 = 1'b0;
        for (int w = 0; w < 4; w++) send(32'h9000_0000 + 32'(w), 1'b0);
        send(32'h9999_9999, 1'b0);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_level", dwc_level0, 3'd0);
        chk("midrst_valid", acc_cmd_valid0, 1'b0);
        chk("midrst_busy", dwc_busy0, 1'b0);
        chk("midrst_ready", id_cmd_ready0, 1'b0);
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        acc_cmd_ready0 = 1'b1;
        expect_beat(128'hF3F3_F3F3_F2F2_F2F2_F1F1_F1F1_F0F0_F0F0, 3'd4);
        send(32'hF0F0_F0F0, 1'b0);
        send(32'hF1F1_F1F1, 1'b0);
        send(32'hF2F2_F2F2, 1'b0);
        send(32'hF3F3_F3F3, 1'b0);
        idle(3);
        chk("post_midrst_scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("post_midrst_level", dwc_level0, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
